fwd_hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline forwarding logic. It combines four functions:
- EX-stage operand forwarding for NUM_SRC source operands.
- ID-stage load-use stall detection.
- A register scoreboard tracking destinations of an outstanding multi-cycle unit (mul/div).
- A saturating stall-cycle counter.

It sits beside the ID/EX pipeline registers and drives the EX operand muxes plus the PC/IF-ID hold and ID/EX bubble controls.

---
 rtl/fwd_hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage operand forwarding, ID-stage load-use detection, and a scoreboard for
// outstanding multi-cycle writes, all combined into one pipeline stall request.
module fwd_hazard_scoreboard #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i,
   input  logic                      ex_mem_regwrite_i,
   input  logic [ADDR_W-1:0]         ex_mem_rd_i,
   input  logic                      mem_wb_regwrite_i,
   input  logic [ADDR_W-1:0]         mem_wb_rd_i,
   output logic [NUM_SRC*2-1:0]      fwd_sel_o,
   input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
   input  logic [NUM_SRC-1:0]        id_src_valid_i,
   input  logic                      id_ex_memread_i,
   input  logic [ADDR_W-1:0]         id_ex_rd_i,
   input  logic                      id_mc_req_i,
   input  logic                      mc_issue_i,
   input  logic [ADDR_W-1:0]         mc_issue_rd_i,
   input  logic                      mc_done_i,
   input  logic [ADDR_W-1:0]         mc_done_rd_i,
   output logic                      stall_o,
   output logic                      mc_full_o,
   output logic                      sb_err_o,
   output logic [CNT_W-1:0]          stall_cnt_o
);

   localparam int NREG = 1 << ADDR_W;
   localparam int CW   = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MaxOut = CW'(MAX_OUT);

   logic [NREG-1:0]    pend;
   logic [NREG-1:0]    pendNext;
   logic [CW-1:0]      count;
   logic [CW-1:0]      countNext;
   logic               sbErr;
   logic [CNT_W-1:0]   stallCnt;

   logic               mcFull;
   logic               issueAcc;
   logic               issueWaw;
   logic               issueInc;
   logic               doneValid;
   logic               errEvent;
   logic               loadUse;
   logic               sbHit;
   logic               mcStall;
   logic [NUM_SRC-1:0] luVec;
   logic [NUM_SRC-1:0] hitVec;

   // Per-operand forwarding select and ID-stage hazard terms.
   for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
      logic [ADDR_W-1:0] exSrc;
      logic [ADDR_W-1:0] idSrc;
      logic              exHit;
      logic              wbHit;
      assign exSrc = ex_src_addr_i[s*ADDR_W +: ADDR_W];
      assign idSrc = id_src_addr_i[s*ADDR_W +: ADDR_W];
      assign exHit = ex_mem_regwrite_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == exSrc);
      assign wbHit = mem_wb_regwrite_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == exSrc);
      assign fwd_sel_o[s*2 +: 2] = exHit ? 2'b10 : (wbHit ? 2'b01 : 2'b00);
      assign luVec[s]  = id_src_valid_i[s] && (idSrc == id_ex_rd_i);
      assign hitVec[s] = id_src_valid_i[s] && pend[idSrc];
   end

   assign mcFull   = (count == MaxOut);
   assign issueAcc = mc_issue_i && !mcFull;

   // A same-cycle done of the same register frees the slot, so that is a clean reissue.
   assign issueWaw = issueAcc && (mc_issue_rd_i != '0) && pend[mc_issue_rd_i]
                     && !(doneValid && (mc_done_rd_i == mc_issue_rd_i));
   assign issueInc = issueAcc && !issueWaw;

   assign doneValid = mc_done_i && ((mc_done_rd_i != '0) ? pend[mc_done_rd_i] : (count != '0));
   assign errEvent  = (mc_issue_i && mcFull) || issueWaw || (mc_done_i && !doneValid);

   always_comb begin
      pendNext = pend;
      if (doneValid && (mc_done_rd_i != '0)) begin
         pendNext[mc_done_rd_i] = 1'b0;
      end
      if (issueAcc && (mc_issue_rd_i != '0)) begin
         pendNext[mc_issue_rd_i] = 1'b1;
      end
   end

   always_comb begin
      countNext = count;
      if (issueInc && !doneValid) begin
         countNext = count + CW'(1);
      end else if (!issueInc && doneValid) begin
         countNext = count - CW'(1);
      end
   end

   assign loadUse = id_ex_memread_i && (id_ex_rd_i != '0) && (|luVec);
   assign sbHit   = |hitVec;
   assign mcStall = id_mc_req_i && mcFull;
   assign stall_o = loadUse || sbHit || mcStall;

   // Scoreboard state, sticky error and saturating stall counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend     <= '0;
         count    <= '0;
         sbErr    <= 1'b0;
         stallCnt <= '0;
      end else begin
         pend  <= pendNext;
         count <= countNext;
         if (errEvent) begin
            sbErr <= 1'b1;
         end
         if (stall_o && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
         end
      end
   end

   assign mc_full_o   = mcFull;
   assign sb_err_o    = sbErr;
   assign stall_cnt_o = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with hand-computed expectations
// (MAX_OUT=4, CNT_W=4 so saturation is reachable quickly).
module tb_fwd_hazard_scoreboard;

   localparam int ADDR_W  = 5;
   localparam int NUM_SRC = 2;
   localparam int MAX_OUT = 4;
   localparam int CNT_W   = 4;

   logic                      clk;
   logic                      rst;
   logic [NUM_SRC*ADDR_W-1:0] exSrc;
   logic                      exMemWr;
   logic [ADDR_W-1:0]         exMemRd;
   logic                      memWbWr;
   logic [ADDR_W-1:0]         memWbRd;
   logic [NUM_SRC*2-1:0]      fwdSel;
   logic [NUM_SRC*ADDR_W-1:0] idSrc;
   logic [NUM_SRC-1:0]        idValid;
   logic                      idExMemRead;
   logic [ADDR_W-1:0]         idExRd;
   logic                      idMcReq;
   logic                      mcIssue;
   logic [ADDR_W-1:0]         mcIssueRd;
   logic                      mcDone;
   logic [ADDR_W-1:0]         mcDoneRd;
   logic                      stall;
   logic                      mcFull;
   logic                      sbErr;
   logic [CNT_W-1:0]          stallCnt;

   int total = 0;
   int bad   = 0;

   fwd_hazard_scoreboard #(
      .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .ex_src_addr_i(exSrc),
      .ex_mem_regwrite_i(exMemWr), .ex_mem_rd_i(exMemRd),
      .mem_wb_regwrite_i(memWbWr), .mem_wb_rd_i(memWbRd),
      .fwd_sel_o(fwdSel),
      .id_src_addr_i(idSrc), .id_src_valid_i(idValid),
      .id_ex_memread_i(idExMemRead), .id_ex_rd_i(idExRd),
      .id_mc_req_i(idMcReq),
      .mc_issue_i(mcIssue), .mc_issue_rd_i(mcIssueRd),
      .mc_done_i(mcDone), .mc_done_rd_i(mcDoneRd),
      .stall_o(stall), .mc_full_o(mcFull), .sb_err_o(sbErr),
      .stall_cnt_o(stallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issueReg(input logic [ADDR_W-1:0] rd);
      mcIssue   = 1'b1;
      mcIssueRd = rd;
      nextCycle();
      mcIssue   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      exSrc = '0; exMemWr = 0; exMemRd = '0; memWbWr = 0; memWbRd = '0;
      idSrc = '0; idValid = '0; idExMemRead = 0; idExRd = '0; idMcReq = 0;
      mcIssue = 0; mcIssueRd = '0; mcDone = 0; mcDoneRd = '0;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("rstCnt", 32'(stallCnt), 0);
      checkOutput("rstFull", 32'(mcFull), 0);
      checkOutput("rstErr", 32'(sbErr), 0);
      checkOutput("rstStall", 32'(stall), 0);

      // Forwarding priority
      exMemWr = 1; exMemRd = 5'd3; memWbWr = 1; memWbRd = 5'd3;
      exSrc = {5'd0, 5'd3};
      #1 checkOutput("fwdExMem", 32'(fwdSel), 32'b0010);
      exMemWr = 0;
      #1 checkOutput("fwdMemWb", 32'(fwdSel), 32'b0001);
      exSrc = {5'd3, 5'd3}; exMemWr = 1;
      #1 checkOutput("fwdBoth", 32'(fwdSel), 32'b1010);
      exMemRd = 5'd0; exSrc = {5'd0, 5'd3};
      #1 checkOutput("fwdRd0", 32'(fwdSel), 32'b0001);
      memWbRd = 5'd0;
      #1 checkOutput("fwdNone", 32'(fwdSel), 32'b0000);
      exMemWr = 0; memWbWr = 0;

      // Load-use
      idExMemRead = 1; idExRd = 5'd7; idSrc = {5'd7, 5'd2}; idValid = 2'b10;
      #1 checkOutput("luStall", 32'(stall), 1);
      checkOutput("luCnt0", 32'(stallCnt), 0);
      nextCycle();
      checkOutput("luCnt1", 32'(stallCnt), 1);
      nextCycle();
      checkOutput("luCnt2", 32'(stallCnt), 2);
      idValid = 2'b01;
      #1 checkOutput("luInvalid", 32'(stall), 0);
      nextCycle();
      checkOutput("luCntHold", 32'(stallCnt), 2);
      idValid = 2'b10; idExRd = 5'd0;
      #1 checkOutput("luRd0", 32'(stall), 0);
      idExMemRead = 0; idValid = '0;

      // Scoreboard hit and release timing
      mcIssue = 1; mcIssueRd = 5'd9; idSrc = {5'd0, 5'd9}; idValid = 2'b01;
      #1 checkOutput("sbPreEdge", 32'(stall), 0);
      nextCycle();
      mcIssue = 0;
      #1 checkOutput("sbHit", 32'(stall), 1);
      mcDone = 1; mcDoneRd = 5'd9;
      #1 checkOutput("sbDoneSame", 32'(stall), 1);
      nextCycle();
      mcDone = 0;
      #1 checkOutput("sbReleased", 32'(stall), 0);
      checkOutput("sbCnt", 32'(stallCnt), 3);
      idValid = '0;

      // Simultaneous issue and done of rd 6, then a stray done
      issueReg(5'd6);
      mcIssue = 1; mcIssueRd = 5'd6; mcDone = 1; mcDoneRd = 5'd6;
      nextCycle();
      mcIssue = 0; mcDone = 0;
      idSrc = {5'd0, 5'd6}; idValid = 2'b01;
      #1 checkOutput("sameRdPend", 32'(stall), 1);
      checkOutput("sameRdFull", 32'(mcFull), 0);
      idValid = '0;
      mcDone = 1; mcDoneRd = 5'd12;
      nextCycle();
      mcDone = 0;
      #1 checkOutput("strayDoneErr", 32'(sbErr), 1);
      nextCycle();
      checkOutput("errSticky", 32'(sbErr), 1);
      checkOutput("cntBeforeRst", 32'(stallCnt), 3);
      #3 rst = 1;
      #1 checkOutput("asyncRstErr", 32'(sbErr), 0);
      checkOutput("asyncRstCnt", 32'(stallCnt), 0);
      #1 rst = 0;

      // Fill to MAX_OUT, overflow attempts
      issueReg(5'd1); issueReg(5'd2); issueReg(5'd3);
      #1 checkOutput("fullAt3", 32'(mcFull), 0);
      issueReg(5'd4);
      #1 checkOutput("fullAt4", 32'(mcFull), 1);
      idMcReq = 1;
      #1 checkOutput("mcStall", 32'(stall), 1);
      idMcReq = 0;
      issueReg(5'd5);
      #1 checkOutput("overflowErr", 32'(sbErr), 1);
      checkOutput("overflowFull", 32'(mcFull), 1);
      idSrc = {5'd0, 5'd5}; idValid = 2'b01;
      #1 checkOutput("overflowNoPend", 32'(stall), 0);
      idValid = '0;
      rst = 1;
      #1 rst = 0;
      #1 checkOutput("rstClearsFull", 32'(mcFull), 0);
      issueReg(5'd1); issueReg(5'd2); issueReg(5'd3); issueReg(5'd4);
      mcIssue = 1; mcIssueRd = 5'd5; mcDone = 1; mcDoneRd = 5'd1;
      nextCycle();
      mcIssue = 0; mcDone = 0;
      #1 checkOutput("fullPreEdgeErr", 32'(sbErr), 1);
      checkOutput("fullPreEdgeCount", 32'(mcFull), 0);
      idSrc = {5'd0, 5'd5}; idValid = 2'b01;
      #1 checkOutput("rd5Rejected", 32'(stall), 0);
      idSrc = {5'd0, 5'd1};
      #1 checkOutput("rd1Cleared", 32'(stall), 0);
      idSrc = {5'd0, 5'd2};
      #1 checkOutput("rd2Pending", 32'(stall), 1);
      idValid = '0;
      issueReg(5'd6);
      #1 checkOutput("refull", 32'(mcFull), 1);

      // Counter saturation, then asynchronous reset between edges
      idExMemRead = 1; idExRd = 5'd7; idSrc = {5'd7, 5'd0}; idValid = 2'b10;
      repeat (19) nextCycle();
      checkOutput("cntSat", 32'(stallCnt), 15);
      checkOutput("satFull", 32'(mcFull), 1);
      checkOutput("satErr", 32'(sbErr), 1);
      @(posedge clk);
      #3 rst = 1;
      #1 checkOutput("midRstCnt", 32'(stallCnt), 0);
      checkOutput("midRstFull", 32'(mcFull), 0);
      checkOutput("midRstErr", 32'(sbErr), 0);
      checkOutput("midRstLu", 32'(stall), 1);
      #1 rst = 0;
      idExMemRead = 0;
      #1 checkOutput("finalStall", 32'(stall), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
